// File: rtl/hazard_scoreboard_ctrl.sv
// Decode-stage interlock and forwarding controller: a per-GPR pending-write
// scoreboard plus combinational stall and operand-source selection.
module hazard_scoreboard_ctrl #(
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 2,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ds_valid,
    input  logic [4:0]        ds_raddr1,
    input  logic [4:0]        ds_raddr2,
    input  logic              ds_rs1_used,
    input  logic              ds_rs2_used,
    input  logic              ds_rf_we,
    input  logic [4:0]        ds_dest,
    input  logic              es_allowin,
    input  logic              es_valid,
    input  logic              es_rf_we,
    input  logic [4:0]        es_dest,
    input  logic              es_is_load,
    input  logic              ms_valid,
    input  logic              ms_rf_we,
    input  logic [4:0]        ms_dest,
    input  logic              ms_is_load,
    input  logic              ms_data_ok,
    input  logic              ws_valid,
    input  logic              ws_rf_we,
    input  logic [4:0]        ws_dest,
    output logic              ds_stall,
    output logic              ds_issue,
    output logic [1:0]        fwd_sel1,
    output logic [1:0]        fwd_sel2,
    output logic              sb_busy,
    output logic              sb_error,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt [32];

    logic [1:0][4:0] raddr;
    logic [1:0]      used;
    logic [1:0]      pend;
    logic [1:0]      hazard;
    logic [1:0]      mismatch;
    logic [1:0][1:0] prod;
    logic            inc;
    logic            dec;
    logic            same_reg;
    logic [31:0]     inc_vec;
    logic [31:0]     dec_vec;
    logic            err_set;

    // NOTE: every signal written here gets a default first, so no path leaves a latch.
    always_comb begin
        raddr    = {ds_raddr2, ds_raddr1};
        used     = {ds_rs2_used, ds_rs1_used};
        pend     = '0;
        hazard   = '0;
        mismatch = '0;
        prod     = '0;
        for (int s = 0; s < 2; s++) begin
            pend[s] = used[s] && (raddr[s] != 5'd0) && (cnt[raddr[s]] != '0);
            // Youngest writer wins: EX, then MEM, then WB.
            if (es_valid && es_rf_we && (es_dest == raddr[s])) begin
                prod[s]   = 2'b01;
                hazard[s] = pend[s] && es_is_load;
            end else if (ms_valid && ms_rf_we && (ms_dest == raddr[s])) begin
                prod[s]   = 2'b10;
                hazard[s] = pend[s] && ms_is_load && !ms_data_ok;
            end else if (ws_valid && ws_rf_we && (ws_dest == raddr[s])) begin
                prod[s]   = 2'b11;
            end else begin
                hazard[s]   = pend[s];
                mismatch[s] = pend[s];
            end
        end

        if (FWD_EN) ds_stall = ds_valid && (hazard != '0);
        else        ds_stall = ds_valid && (pend != '0);

        fwd_sel1 = (FWD_EN && pend[0] && !ds_stall) ? prod[0] : 2'b00;
        fwd_sel2 = (FWD_EN && pend[1] && !ds_stall) ? prod[1] : 2'b00;
        ds_issue = ds_valid && !ds_stall && es_allowin;

        inc      = ds_issue && ds_rf_we && (ds_dest != 5'd0);
        dec      = ws_valid && ws_rf_we && (ws_dest != 5'd0);
        same_reg = inc && dec && (ds_dest == ws_dest);
        inc_vec  = inc ? (32'd1 << ds_dest) : 32'd0;
        dec_vec  = dec ? (32'd1 << ws_dest) : 32'd0;

        err_set  = (FWD_EN && ds_valid && (mismatch != '0))
                || (inc && !same_reg && (cnt[ds_dest] == CNT_MAX))
                || (dec && !same_reg && (cnt[ws_dest] == '0));

        sb_busy = 1'b0;
        for (int r = 0; r < 32; r++) begin
            if (cnt[r] != '0) sb_busy = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every counter samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the counter array is architectural state and must be cleared, unlike a data RAM.
            for (int r = 0; r < 32; r++) cnt[r] <= '0;
            sb_error     <= 1'b0;
            stall_cycles <= '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    if (cnt[r] != CNT_MAX) cnt[r] <= cnt[r] + 1'b1;
                end else if (dec_vec[r] && !inc_vec[r]) begin
                    if (cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
                end
            end
            if (err_set) sb_error <= 1'b1;
            if (ds_valid && ds_stall && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Bench for hazard_scoreboard_ctrl: directed scenarios then random traffic, both
// forwarding and pure-interlock builds checked against a scoreboard model.
module tb_hazard_scoreboard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       ds_valid, ds_rs1_used, ds_rs2_used, ds_rf_we, es_allowin;
    logic [4:0] ds_raddr1, ds_raddr2, ds_dest, es_dest, ms_dest, ws_dest;
    logic       es_valid, es_rf_we, es_is_load;
    logic       ms_valid, ms_rf_we, ms_is_load, ms_data_ok;
    logic       ws_valid, ws_rf_we;

    logic [1:0]  ds_stall, ds_issue, sb_busy, sb_error;
    logic [1:0]  fwd_sel1 [2];
    logic [1:0]  fwd_sel2 [2];
    logic [31:0] stall_cycles [2];

    hazard_scoreboard_ctrl #(.FWD_EN(1'b1), .CNT_W(2), .PERF_W(32)) dut (
        .clk(clk), .reset(reset), .ds_valid(ds_valid), .ds_raddr1(ds_raddr1), .ds_raddr2(ds_raddr2),
        .ds_rs1_used(ds_rs1_used), .ds_rs2_used(ds_rs2_used), .ds_rf_we(ds_rf_we), .ds_dest(ds_dest),
        .es_allowin(es_allowin), .es_valid(es_valid), .es_rf_we(es_rf_we), .es_dest(es_dest),
        .es_is_load(es_is_load), .ms_valid(ms_valid), .ms_rf_we(ms_rf_we), .ms_dest(ms_dest),
        .ms_is_load(ms_is_load), .ms_data_ok(ms_data_ok), .ws_valid(ws_valid), .ws_rf_we(ws_rf_we),
        .ws_dest(ws_dest), .ds_stall(ds_stall[0]), .ds_issue(ds_issue[0]), .fwd_sel1(fwd_sel1[0]),
        .fwd_sel2(fwd_sel2[0]), .sb_busy(sb_busy[0]), .sb_error(sb_error[0]),
        .stall_cycles(stall_cycles[0])
    );

    hazard_scoreboard_ctrl #(.FWD_EN(1'b0), .CNT_W(2), .PERF_W(32)) dut_nf (
        .clk(clk), .reset(reset), .ds_valid(ds_valid), .ds_raddr1(ds_raddr1), .ds_raddr2(ds_raddr2),
        .ds_rs1_used(ds_rs1_used), .ds_rs2_used(ds_rs2_used), .ds_rf_we(ds_rf_we), .ds_dest(ds_dest),
        .es_allowin(es_allowin), .es_valid(es_valid), .es_rf_we(es_rf_we), .es_dest(es_dest),
        .es_is_load(es_is_load), .ms_valid(ms_valid), .ms_rf_we(ms_rf_we), .ms_dest(ms_dest),
        .ms_is_load(ms_is_load), .ms_data_ok(ms_data_ok), .ws_valid(ws_valid), .ws_rf_we(ws_rf_we),
        .ws_dest(ws_dest), .ds_stall(ds_stall[1]), .ds_issue(ds_issue[1]), .fwd_sel1(fwd_sel1[1]),
        .fwd_sel2(fwd_sel2[1]), .sb_busy(sb_busy[1]), .sb_error(sb_error[1]),
        .stall_cycles(stall_cycles[1])
    );

    int total = 0;
    int bad   = 0;

    // Reference state per build: index 0 forwarding, index 1 pure interlock.
    int  mcnt [2][32];
    bit  merr [2];
    int  mstalls [2];
    bit  exp_stall [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        ds_valid = 0; ds_raddr1 = 0; ds_raddr2 = 0; ds_rs1_used = 0; ds_rs2_used = 0;
        ds_rf_we = 0; ds_dest = 0; es_allowin = 1;
        es_valid = 0; es_rf_we = 0; es_dest = 0; es_is_load = 0;
        ms_valid = 0; ms_rf_we = 0; ms_dest = 0; ms_is_load = 0; ms_data_ok = 0;
        ws_valid = 0; ws_rf_we = 0; ws_dest = 0;
    endtask

    // Expected stall/selects for build k from the pipeline's stage contents and the model counts.
    function automatic void model_eval(input int k, output bit stall, output bit [1:0] sel1,
                                       output bit [1:0] sel2, output bit mis);
        bit [4:0] a [2];
        bit       u [2];
        bit       pend [2];
        bit       hz [2];
        bit [1:0] src [2];
        a[0] = ds_raddr1; a[1] = ds_raddr2;
        u[0] = ds_rs1_used; u[1] = ds_rs2_used;
        for (int s = 0; s < 2; s++) begin
            pend[s] = u[s] && a[s] != 0 && mcnt[k][a[s]] > 0;
            if (es_valid && es_rf_we && es_dest == a[s]) begin
                src[s] = 2'b01; hz[s] = es_is_load;
            end else if (ms_valid && ms_rf_we && ms_dest == a[s]) begin
                src[s] = 2'b10; hz[s] = ms_is_load && !ms_data_ok;
            end else if (ws_valid && ws_rf_we && ws_dest == a[s]) begin
                src[s] = 2'b11; hz[s] = 0;
            end else begin
                src[s] = 2'b00; hz[s] = 1;
            end
        end
        if (k == 0) begin
            stall = ds_valid && ((pend[0] && hz[0]) || (pend[1] && hz[1]));
            sel1  = (pend[0] && !stall) ? src[0] : 2'b00;
            sel2  = (pend[1] && !stall) ? src[1] : 2'b00;
            mis   = ds_valid && ((pend[0] && src[0] == 0) || (pend[1] && src[1] == 0));
        end else begin
            stall = ds_valid && (pend[0] || pend[1]);
            sel1  = 2'b00;
            sel2  = 2'b00;
            mis   = 0;
        end
    endfunction

    bit exp_mis [2];

    task automatic settle();
        bit       st, mis, busy;
        bit [1:0] s1, s2;
        #1;
        for (int k = 0; k < 2; k++) begin
            model_eval(k, st, s1, s2, mis);
            exp_stall[k] = st;
            exp_mis[k]   = mis;
            busy = 0;
            for (int r = 0; r < 32; r++) if (mcnt[k][r] != 0) busy = 1;
            check($sformatf("ds_stall[%0d]", k), ds_stall[k], st);
            check($sformatf("ds_issue[%0d]", k), ds_issue[k], ds_valid && !st && es_allowin);
            check($sformatf("fwd_sel1[%0d]", k), fwd_sel1[k], s1);
            check($sformatf("fwd_sel2[%0d]", k), fwd_sel2[k], s2);
            check($sformatf("sb_busy[%0d]", k), sb_busy[k], busy);
            check($sformatf("sb_error[%0d]", k), sb_error[k], merr[k]);
            check($sformatf("stall_cycles[%0d]", k), stall_cycles[k], mstalls[k]);
        end
    endtask

    task automatic tick();
        bit issue, inc, dec;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int r = 0; r < 32; r++) mcnt[k][r] = 0;
                merr[k] = 0;
                mstalls[k] = 0;
            end else begin
                issue = ds_valid && !exp_stall[k] && es_allowin;
                inc   = issue && ds_rf_we && ds_dest != 0;
                dec   = ws_valid && ws_rf_we && ws_dest != 0;
                if (!(inc && dec && ds_dest == ws_dest)) begin
                    if (inc) begin
                        if (mcnt[k][ds_dest] == 3) merr[k] = 1;
                        else mcnt[k][ds_dest]++;
                    end
                    if (dec) begin
                        if (mcnt[k][ws_dest] == 0) merr[k] = 1;
                        else mcnt[k][ws_dest]--;
                    end
                end
                if (exp_mis[k]) merr[k] = 1;
                if (ds_valid && exp_stall[k]) mstalls[k]++;
            end
        end
        #1;
    endtask

    initial begin
        clear_in();
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) mcnt[k][r] = 0;
            merr[k] = 0; mstalls[k] = 0;
        end
        settle();
        check("reset_busy", sb_busy[0], 0);
        check("reset_stall", ds_stall[0], 0);
        check("reset_sel1", fwd_sel1[0], 2'b00);

        // add r5, then a reader with r5 in EX
        clear_in(); ds_valid = 1; ds_rf_we = 1; ds_dest = 5;
        settle(); check("add_issue", ds_issue[0], 1); tick();
        check("add_busy", sb_busy[0], 1);
        clear_in(); ds_valid = 1; ds_rs1_used = 1; ds_raddr1 = 5;
        es_valid = 1; es_rf_we = 1; es_dest = 5;
        settle(); check("ex_fwd_stall", ds_stall[0], 0); check("ex_fwd_sel1", fwd_sel1[0], 2'b01); tick();
        clear_in(); ms_valid = 1; ms_rf_we = 1; ms_dest = 5; settle(); tick();
        clear_in(); ws_valid = 1; ws_rf_we = 1; ws_dest = 5; settle(); tick();
        check("commit_idle", sb_busy[0], 0);

        // load-use on r7 through rs2
        clear_in(); ds_valid = 1; ds_rf_we = 1; ds_dest = 7; settle(); tick();
        clear_in(); ds_valid = 1; ds_rs2_used = 1; ds_raddr2 = 7;
        es_valid = 1; es_rf_we = 1; es_dest = 7; es_is_load = 1;
        settle(); check("load_use_stall", ds_stall[0], 1); tick();
        clear_in(); ds_valid = 1; ds_rs2_used = 1; ds_raddr2 = 7;
        ms_valid = 1; ms_rf_we = 1; ms_dest = 7; ms_is_load = 1; ms_data_ok = 1;
        settle(); check("load_mem_stall", ds_stall[0], 0); check("load_mem_sel2", fwd_sel2[0], 2'b10); tick();
        check("load_stall_cnt", stall_cycles[0], 1);
        clear_in(); ws_valid = 1; ws_rf_we = 1; ws_dest = 7; settle(); tick();

        // two writers of r3: youngest wins, then WB only
        clear_in(); ds_valid = 1; ds_rf_we = 1; ds_dest = 3; settle(); tick();
        settle(); tick();
        clear_in(); ds_valid = 1; ds_rs1_used = 1; ds_raddr1 = 3;
        es_valid = 1; es_rf_we = 1; es_dest = 3; ms_valid = 1; ms_rf_we = 1; ms_dest = 3;
        settle(); check("youngest_ex", fwd_sel1[0], 2'b01); tick();
        clear_in(); ds_valid = 1; ds_rs1_used = 1; ds_raddr1 = 3;
        ms_valid = 1; ms_rf_we = 1; ms_dest = 3; ws_valid = 1; ws_rf_we = 1; ws_dest = 3;
        settle(); check("youngest_mem", fwd_sel1[0], 2'b10); tick();
        clear_in(); ds_valid = 1; ds_rs1_used = 1; ds_raddr1 = 3;
        ws_valid = 1; ws_rf_we = 1; ws_dest = 3;
        settle(); check("wb_only", fwd_sel1[0], 2'b11); tick();
        check("r3_drained", sb_busy[0], 0);

        // same-cycle increment and decrement of r4; r0 traffic
        clear_in(); ds_valid = 1; ds_rf_we = 1; ds_dest = 4; settle(); tick();
        ws_valid = 1; ws_rf_we = 1; ws_dest = 4; settle(); tick();
        check("inc_dec_busy", sb_busy[0], 1);
        clear_in(); ws_valid = 1; ws_rf_we = 1; ws_dest = 4; settle(); tick();
        check("inc_dec_drain", sb_busy[0], 0);
        clear_in(); ds_valid = 1; ds_rf_we = 1; ds_dest = 0; ds_rs1_used = 1; ds_rs2_used = 1;
        es_valid = 1; es_rf_we = 1; es_dest = 0;
        settle(); check("r0_stall", ds_stall[0], 0); check("r0_sel1", fwd_sel1[0], 2'b00);
        check("r0_sel2", fwd_sel2[0], 2'b00); tick();
        check("r0_busy", sb_busy[0], 0);

        // pure interlock on r9
        clear_in(); ds_valid = 1; ds_rf_we = 1; ds_dest = 9; settle(); tick();
        clear_in(); ds_valid = 1; ds_rs1_used = 1; ds_raddr1 = 9;
        ms_valid = 1; ms_rf_we = 1; ms_dest = 9;
        settle(); check("nf_mem_stall", ds_stall[1], 1); check("nf_mem_sel", fwd_sel1[1], 2'b00);
        check("fwd_mem_sel", fwd_sel1[0], 2'b10); tick();
        clear_in(); ds_valid = 1; ds_rs1_used = 1; ds_raddr1 = 9;
        ws_valid = 1; ws_rf_we = 1; ws_dest = 9;
        settle(); check("nf_wb_stall", ds_stall[1], 1); tick();
        clear_in(); ds_valid = 1; ds_rs1_used = 1; ds_raddr1 = 9;
        settle(); check("nf_clear_stall", ds_stall[1], 0); check("nf_clear_sel", fwd_sel1[1], 2'b00); tick();

        // underflow on r2 is sticky
        check("pre_err", sb_error[0], 0);
        clear_in(); ws_valid = 1; ws_rf_we = 1; ws_dest = 2; settle(); tick();
        check("underflow_err", sb_error[0], 1);
        clear_in(); settle(); tick();
        check("err_sticky", sb_error[0], 1);

        // random traffic on a narrow register window so stages collide often
        for (int i = 0; i < 600; i++) begin
            ds_valid = 1'($urandom); ds_rs1_used = 1'($urandom); ds_rs2_used = 1'($urandom);
            ds_raddr1 = 5'($urandom_range(0, 7)); ds_raddr2 = 5'($urandom_range(0, 7));
            ds_rf_we = 1'($urandom); ds_dest = 5'($urandom_range(0, 7));
            es_allowin = ($urandom_range(0, 3) != 0);
            es_valid = 1'($urandom); es_rf_we = 1'($urandom); es_dest = 5'($urandom_range(0, 7));
            es_is_load = 1'($urandom);
            ms_valid = 1'($urandom); ms_rf_we = 1'($urandom); ms_dest = 5'($urandom_range(0, 7));
            ms_is_load = 1'($urandom); ms_data_ok = 1'($urandom);
            ws_valid = 1'($urandom); ws_rf_we = 1'($urandom); ws_dest = 5'($urandom_range(0, 7));
            settle();
            tick();
        end

        // reset mid-stream with pending state
        clear_in(); ds_valid = 1; ds_rf_we = 1; ds_dest = 6; ds_rs1_used = 1; ds_raddr1 = 6;
        reset = 1; settle(); tick();
        reset = 0; clear_in();
        check("rst_busy", sb_busy[0], 0);
        check("rst_err", sb_error[0], 0);
        check("rst_stalls", stall_cycles[0], 0);
        check("rst_err_nf", sb_error[1], 0);
        settle(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
